// File: rtl/sipo_deser.sv
// Parametrised serial-to-parallel deserializer with a valid/ready holding register and overrun flag.
// Define SIPO_PARITY_EN to add a trailing even-parity bit per frame and the parity_err output.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, cnt_eff, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             shift_en, complete, load, ovr_set;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  // sync_clr realigns the frame before the current bit is counted
  always_comb begin
    cnt_eff  = sync_clr ? '0 : bit_cnt;
    complete = serial_valid && (cnt_eff == LAST);
`ifdef SIPO_PARITY_EN
    shift_en = serial_valid && (cnt_eff != CNT_W'(WIDTH));
`else
    shift_en = serial_valid;
`endif
    shreg_nxt = shift_en ? shift_in(shreg, serial_in) : shreg;
    if (!serial_valid) cnt_nxt = cnt_eff;
    else if (complete) cnt_nxt = '0;
    else               cnt_nxt = cnt_eff + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          if (out_ready) load    = 1'b1;
          else           ovr_set = 1'b1;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // stage boundary: frame assembly -> holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      out_data <= '0;
      overrun  <= 1'b0;
    end else begin
      bit_cnt <= cnt_nxt;
      shreg   <= shreg_nxt;
      overrun <= ovr_set;
      if (load) out_data <= shreg_nxt;
    end
  end

`ifdef SIPO_PARITY_EN
  // parity bit arrives after the full word, so shreg_nxt already holds the data
  always_ff @(posedge clk) begin
    if (reset)                            parity_err <= 1'b0;
    else if (load)                        parity_err <= (^shreg_nxt) ^ serial_in;
    else if (state == FULL && out_ready)  parity_err <= 1'b0;
  end
`endif

  assign out_valid = (state == FULL);
  assign busy      = (bit_cnt != '0);

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench: two DUTs (MSB-first and LSB-first) share stimulus and are compared
// every cycle against a frame-level model, plus directed literal checks.
`timescale 1ns/1ps
module tb_sipo_deser;
  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         serial_in = 1'b0, serial_valid = 1'b0, sync_clr = 1'b0, out_ready = 1'b0;
  logic [W-1:0] data_m, data_l;
  logic         valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
  logic         perr_m, perr_l;

  int checks = 0;
  int errors = 0;

  // model state
  bit           mdl_on = 1'b0;
  logic         frame[$];
  int           nbits = 0;
  logic [W-1:0] exp_m = '0, exp_l = '0;
  logic         exp_valid = 1'b0, exp_ovr = 1'b0, exp_perr = 1'b0;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .sync_clr(sync_clr), .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready),
    .busy(busy_m), .overrun(ovr_m)
`ifdef SIPO_PARITY_EN
    , .parity_err(perr_m)
`endif
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .sync_clr(sync_clr), .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
    .busy(busy_l), .overrun(ovr_l)
`ifdef SIPO_PARITY_EN
    , .parity_err(perr_l)
`endif
  );

`ifndef SIPO_PARITY_EN
  assign perr_m = 1'b0;
  assign perr_l = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect bits, build words when a frame completes
  initial forever begin
    logic         done, parbit;
    logic [W-1:0] wm, wl;
    @(posedge clk);
    if (reset) begin
      mdl_on = 1'b1;
      frame.delete();
      nbits = 0;
      exp_m = '0; exp_l = '0;
      exp_valid = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
    end else begin
      done = 1'b0;
      parbit = 1'b0;
      exp_ovr = 1'b0;
      if (sync_clr) begin
        nbits = 0;
        frame.delete();
      end
      if (serial_valid) begin
        if (nbits < W) frame.push_back(serial_in);
        else           parbit = serial_in;
        nbits++;
        if (nbits == FL) begin
          done = 1'b1;
          nbits = 0;
        end
      end
      if (done) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = frame[i];
          wl[i]     = frame[i];
        end
        frame.delete();
        if (!exp_valid || out_ready) begin
          exp_m = wm;
          exp_l = wl;
          exp_valid = 1'b1;
`ifdef SIPO_PARITY_EN
          exp_perr = (^wm) ^ parbit;
`endif
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (exp_valid && out_ready) begin
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
      end
    end
  end

  // per-cycle compare on the falling edge
  initial forever begin
    @(negedge clk);
    if (mdl_on) begin
      check("data_m", data_m, exp_m);
      check("data_l", data_l, exp_l);
      check("valid_m", valid_m, exp_valid);
      check("valid_l", valid_l, exp_valid);
      check("busy_m", busy_m, nbits != 0);
      check("busy_l", busy_l, nbits != 0);
      check("ovr_m", ovr_m, exp_ovr);
      check("ovr_l", ovr_l, exp_ovr);
`ifdef SIPO_PARITY_EN
      check("perr_m", perr_m, exp_perr);
      check("perr_l", perr_l, exp_perr);
`endif
    end
  end

  task automatic cyc(input logic v, input logic b, input logic sc);
    serial_valid = v;
    serial_in    = b;
    sync_clr     = sc;
    @(posedge clk);
    #1;
    serial_valid = 1'b0;
    sync_clr     = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic par_flip, input bit gaps);
    for (int i = W - 1; i >= 0; i--) begin
      if (gaps) cyc(1'b0, ~w[i], 1'b0);
      cyc(1'b1, w[i], 1'b0);
    end
`ifdef SIPO_PARITY_EN
    cyc(1'b1, (^w) ^ par_flip, 1'b0);
`endif
  endtask

  initial begin
    logic [W-1:0] a5;
    a5 = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", valid_m, 1'b0);
    check("rst_data", data_m, 8'h00);
    check("rst_busy", busy_m, 1'b0);

    // basic word, both bit orders
    out_ready = 1'b1;
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    check("busy_mid", busy_m, 1'b1);
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    cyc(1'b1, 1'b0, 1'b0);
`endif
    check("lit_valid", valid_m, 1'b1);
    check("lit_msb", data_m, 8'hB2);
    check("lit_lsb", data_l, 8'h4D);
    check("mdl_msb", exp_m, 8'hB2);
    check("mdl_lsb", exp_l, 8'h4D);
    check("busy_end", busy_m, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("consumed", valid_m, 1'b0);

    // serial_valid gaps
    send_word(8'hB2, 1'b0, 1'b1);
    check("gap_data", data_m, 8'hB2);
    check("gap_valid", valid_m, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("gap_once", valid_m, 1'b0);

    // overrun with out_ready held low
    out_ready = 1'b0;
    send_word(8'hB2, 1'b0, 1'b0);
    send_word(8'h11, 1'b0, 1'b0);
    check("ovr_pulse", ovr_m, 1'b1);
    check("ovr_keep", data_m, 8'hB2);
    check("mdl_ovr", exp_ovr, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("ovr_one", ovr_m, 1'b0);
    check("ovr_hold", valid_m, 1'b1);
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("ovr_xfer", valid_m, 1'b0);

    // sync_clr realignment
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, a5[7], 1'b1);
    check("sync_busy", busy_m, 1'b1);
    for (int i = 6; i >= 0; i--) cyc(1'b1, a5[i], 1'b0);
`ifdef SIPO_PARITY_EN
    cyc(1'b1, ^a5, 1'b0);
`endif
    check("sync_data", data_m, 8'hA5);
    check("sync_lsb", data_l, 8'hA5);
    check("mdl_sync", exp_m, 8'hA5);

    // reset mid-frame with a held word
    out_ready = 1'b0;
    send_word(8'h3C, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    check("pre_rst_busy", busy_m, 1'b1);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check("mid_rst_data", data_m, 8'h00);
    check("mid_rst_valid", valid_m, 1'b0);
    check("mid_rst_busy", busy_m, 1'b0);
    check("mid_rst_ovr", ovr_m, 1'b0);

`ifdef SIPO_PARITY_EN
    send_word(8'hB2, 1'b0, 1'b0);
    check("par_ok", perr_m, 1'b0);
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    send_word(8'hB2, 1'b1, 1'b0);
    check("par_bad", perr_m, 1'b1);
    check("par_valid", valid_m, 1'b1);
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("par_clr", perr_m, 1'b0);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 199) == 0);
      out_ready    = ($urandom_range(0, 1) == 1);
      serial_in    = $urandom_range(0, 1);
      serial_valid = ($urandom_range(0, 9) < 7);
      sync_clr     = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    serial_valid = 1'b0;
    sync_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Parametrised serial-to-parallel deserializer; successor to the fixed 4-bit SIPO shift register.
- Adds configurable word width and bit order, a serial qualifier (`serial_valid`), and frame realignment.
- Adds a holding register with a valid/ready output handshake, plus overrun detection.
- Sits between a bit-serial receive front end and word-oriented downstream logic (FIFO, decoder).

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = first received bit lands in out_data[WIDTH-1]; 0 = first received bit lands in out_data[0].

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  serial data bit, sampled only when serial_valid=1.
- serial_valid  input  1  qualifies serial_in for this cycle.
- sync_clr  input  1  frame realign: discards any partial word.
- out_data  output  WIDTH  completed word from the holding register.
- out_valid  output  1  holding register contains an unconsumed word.
- out_ready  input  1  downstream accepts out_data this cycle.
- busy  output  1  partial frame in progress (bit counter != 0).
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- parity_err  output  1  present only with SIPO_PARITY_EN; see Optional Feature.

Behaviour:
- Reset:
  - One clock; reset is synchronous, active-high, and has highest priority.
  - Clears shift register, bit counter, out_data, out_valid, busy, overrun and parity_err to 0.
  - Reset mid-frame discards the partial word and any held word.
- Bit counter: bit_cnt, width $clog2(FRAME_LEN).
  - FRAME_LEN = WIDTH, or WIDTH+1 with SIPO_PARITY_EN.
  - Increments on each accepted bit.
  - Wraps to 0 after the bit at FRAME_LEN-1.
  - busy = (bit_cnt != 0).
- Shift register:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: shreg <= {serial_in, shreg[WIDTH-1:1]}.
  - No shift when serial_valid=0; the counter and shift register hold.
- sync_clr:
  - Forces bit_cnt to 0 and discards the partial word.
  - Does not affect the holding register, out_valid or out_data.
  - If sync_clr=1 and serial_valid=1 in the same cycle, that bit is accepted as bit 0 of a new frame (bit_cnt becomes 1).
- Word completion: occurs when serial_valid=1 and bit_cnt = FRAME_LEN-1.
  - The completed word is the shift-register contents including the current bit.
- Output state machine, EMPTY (out_valid=0) / FULL (out_valid=1):
  - EMPTY, completion: load out_data, go to FULL. out_valid rises the cycle after the last bit is sampled (latency 1 clock).
  - FULL, out_ready=1, no completion: go to EMPTY.
  - FULL, out_ready=1, completion in the same cycle: load the new word and stay FULL (back-to-back, no bubble).
  - FULL, out_ready=0, completion: drop the new word, keep the held word, pulse overrun for 1 cycle; the frame counter still wraps to 0.
- Handshake rules:
  - A transfer occurs when out_valid && out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_ready is ignored in EMPTY.
- Sustained throughput: one word per WIDTH accepted bits with no loss, provided out_ready is asserted at least once per frame.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Each frame carries one extra trailing even-parity bit; FRAME_LEN = WIDTH+1.
  - The parity bit is not shifted into the data word.
  - On completion, parity_err is registered as (^data_word) ^ parity_bit and loaded together with out_data.
  - parity_err is valid while out_valid=1 and cleared when the word is consumed.
  - A word dropped on overrun does not update parity_err.
- Undefined:
  - parity_err port is absent; FRAME_LEN = WIDTH; no parity logic is synthesised.

Test Plan:
- Reset then 8 bits 1,0,1,1,0,0,1,0 (WIDTH=8, MSB_FIRST=1, out_ready=1): one cycle after the 8th bit, out_valid=1 and out_data=8'hB2; busy=1 during bits 1..7 and 0 afterwards.
- Same bitstream with MSB_FIRST=0: out_data=8'h4D.
- Bits with serial_valid gaps inserted (toggling every other cycle): same out_data=8'hB2; no extra or missing words.
- Hold out_ready=0, send two full words 8'hB2 then 8'h11: out_data stays 8'hB2, overrun pulses exactly 1 cycle at completion of the second word; raising out_ready then yields a single transfer.
- Send 3 bits, assert sync_clr with a valid bit, then send 7 more bits: the word is built from the sync_clr-cycle bit plus those 7 bits; assert reset mid-frame: all outputs 0 on the next cycle.
- SIPO_PARITY_EN defined: send 8'hB2 plus parity 0 -> parity_err=0; send 8'hB2 plus parity 1 -> parity_err=1 with out_valid=1; consume the word -> parity_err=0.
